// File: rtl/dot_product_if.sv
// rtl/dot_product_if.sv - tap operand and result bundle for the five-tap dot product
//
// Purpose: carries the five sample/coefficient pairs into the MAC and the
// combinational and registered results back out.
// Ports (signals):
//   sample0..sample4 - unsigned samples, sample0 newest, sample4 oldest
//   coeff0..coeff4   - unsigned coefficients, coeffk pairs with samplek
//   sum, overflow    - combinational result (mod 2^OW) and wrap flag
//   sum_q, overflow_q- the same, registered on clk
// Modports: master = filter side (drives operands), slave = dot_product.
interface dot_product_if #(
  parameter int DW = 8,
  parameter int OW = 16
);
  logic [DW-1:0] sample0, sample1, sample2, sample3, sample4;
  logic [DW-1:0] coeff0, coeff1, coeff2, coeff3, coeff4;
  logic [OW-1:0] sum;
  logic          overflow;
  logic [OW-1:0] sum_q;
  logic          overflow_q;

  modport master (
    output sample0, sample1, sample2, sample3, sample4,
    output coeff0, coeff1, coeff2, coeff3, coeff4,
    input  sum, overflow, sum_q, overflow_q
  );

  modport slave (
    input  sample0, sample1, sample2, sample3, sample4,
    input  coeff0, coeff1, coeff2, coeff3, coeff4,
    output sum, overflow, sum_q, overflow_q
  );
endinterface

// File: rtl/dot_product.sv
// rtl/dot_product.sv - five-tap unsigned multiply-accumulate for the FIR datapath
//
// Purpose: sum = sample0*coeff0 + ... + sample4*coeff4, all unsigned.
// The result is offered combinationally (zero latency) and as a registered copy.
// Ports:
//   clk   - single clock, registered outputs update on the rising edge
//   reset - asynchronous active-low; clears sum_q/overflow_q only
//   bus   - dot_product_if.slave: operands in, sum/overflow/sum_q/overflow_q out
module dot_product #(
  parameter int DW = 8,
  parameter int OW = 16
) (
  input  logic          clk,
  input  logic          reset,
  dot_product_if.slave  bus
);
  localparam int N  = 5;
  localparam int PW = 2 * DW;   // width of one product
  localparam int FW = PW + 3;   // full-precision sum of five products never wraps

  logic [DW-1:0] smp [N];
  logic [DW-1:0] cof [N];
  logic [FW-1:0] full;

  assign smp[0] = bus.sample0;
  assign smp[1] = bus.sample1;
  assign smp[2] = bus.sample2;
  assign smp[3] = bus.sample3;
  assign smp[4] = bus.sample4;
  assign cof[0] = bus.coeff0;
  assign cof[1] = bus.coeff1;
  assign cof[2] = bus.coeff2;
  assign cof[3] = bus.coeff3;
  assign cof[4] = bus.coeff4;

  // Operands are widened to the full sum width before multiplying so every
  // partial sum is exact; truncation happens only at the output.
  always_comb begin
    full = '0;
    for (int k = 0; k < N; k++) begin
      full = full + (FW'(smp[k]) * FW'(cof[k]));
    end
  end

  assign bus.sum      = full[OW-1:0];
  assign bus.overflow = |full[FW-1:OW];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.sum_q      <= '0;
      bus.overflow_q <= 1'b0;
    end else begin
      bus.sum_q      <= bus.sum;
      bus.overflow_q <= bus.overflow;
    end
  end
endmodule

// File: tb/tb_dot_product.sv
// tb/tb_dot_product.sv - self-checking bench for dot_product
module tb_dot_product;
  logic clk = 1'b0;
  logic reset = 1'b0;

  dot_product_if #(.DW(8), .OW(16)) bus ();

  dot_product #(.DW(8), .OW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Scoreboard of expected registered results: {overflow, sum}
  logic [16:0] sb_q[$];

  // Operand vectors are packed with tap 0 in bits [7:0].
  task automatic drive(input logic [39:0] s, input logic [39:0] c);
    bus.sample0 = s[7:0];   bus.coeff0 = c[7:0];
    bus.sample1 = s[15:8];  bus.coeff1 = c[15:8];
    bus.sample2 = s[23:16]; bus.coeff2 = c[23:16];
    bus.sample3 = s[31:24]; bus.coeff3 = c[31:24];
    bus.sample4 = s[39:32]; bus.coeff4 = c[39:32];
  endtask

  function automatic logic [18:0] model(input logic [39:0] s, input logic [39:0] c);
    logic [18:0] acc;
    acc = '0;
    for (int k = 0; k < 5; k++) begin
      acc = acc + 19'(s[8*k +: 8]) * 19'(c[8*k +: 8]);
    end
    return acc;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    drive(40'h0, 40'h0);
    #1;
    total++;
    if (bus.sum_q !== 16'd0) $display("FAIL reset_sum_q: got %0d expected 0", bus.sum_q);
    else passed++;
    total++;
    if (bus.overflow_q !== 1'b0) $display("FAIL reset_overflow_q: got %0b expected 0", bus.overflow_q);
    else passed++;
    // Registered outputs must hold 0 across edges while reset is low.
    drive({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    @(posedge clk); #1;
    total++;
    if (bus.sum_q !== 16'd0) $display("FAIL reset_hold_sum_q: got %0d expected 0", bus.sum_q);
    else passed++;
    total++;
    if (bus.sum !== 16'd55) $display("FAIL reset_comb_sum: got %0d expected 55", bus.sum);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Fixed vectors: each entry drives once, checks the combinational result
  // immediately and the registered copy after the next rising edge.
  task automatic run_table(input string tag, input logic [39:0] s_tab[3],
                           input logic [39:0] c_tab[3], input logic [15:0] e_sum[3],
                           input logic e_ov[3]);
    logic [16:0] exp_q;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(s_tab[i], c_tab[i]);
      #1;
      total++;
      if (bus.sum !== e_sum[i])
        $display("FAIL %s_sum[%0d]: got %0d expected %0d", tag, i, bus.sum, e_sum[i]);
      else passed++;
      total++;
      if (bus.overflow !== e_ov[i])
        $display("FAIL %s_overflow[%0d]: got %0b expected %0b", tag, i, bus.overflow, e_ov[i]);
      else passed++;
      sb_q.push_back({e_ov[i], e_sum[i]});
      @(posedge clk); #1;
      exp_q = sb_q.pop_front();
      total++;
      if (bus.sum_q !== exp_q[15:0])
        $display("FAIL %s_sum_q[%0d]: got %0d expected %0d", tag, i, bus.sum_q, exp_q[15:0]);
      else passed++;
      total++;
      if (bus.overflow_q !== exp_q[16])
        $display("FAIL %s_overflow_q[%0d]: got %0b expected %0b", tag, i, bus.overflow_q, exp_q[16]);
      else passed++;
    end
  endtask

  task automatic test_patterns();
    logic [39:0] s_tab[3];
    logic [39:0] c_tab[3];
    logic [15:0] e_sum[3];
    logic        e_ov[3];
    s_tab[0] = {8'd255, 8'd3, 8'd99, 8'd17, 8'd200}; c_tab[0] = 40'h0;
    e_sum[0] = 16'd0;   e_ov[0] = 1'b0;
    s_tab[1] = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};       c_tab[1] = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    e_sum[1] = 16'd55;  e_ov[1] = 1'b0;
    s_tab[2] = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10};  c_tab[2] = {8'd2, 8'd0, 8'd0, 8'd0, 8'd1};
    e_sum[2] = 16'd110; e_ov[2] = 1'b0;
    run_table("pattern", s_tab, c_tab, e_sum, e_ov);
  endtask

  task automatic test_overflow_boundary();
    logic [39:0] s_tab[3];
    logic [39:0] c_tab[3];
    logic [15:0] e_sum[3];
    logic        e_ov[3];
    s_tab[0] = {8'd0, 8'd0, 8'd0, 8'd0, 8'd255};
    c_tab[0] = {8'd0, 8'd0, 8'd0, 8'd0, 8'd255};
    e_sum[0] = 16'd65025; e_ov[0] = 1'b0;
    s_tab[1] = {8'd0, 8'd0, 8'd0, 8'd255, 8'd255};
    c_tab[1] = {8'd0, 8'd0, 8'd0, 8'd255, 8'd255};
    e_sum[1] = 16'd64514; e_ov[1] = 1'b1;
    s_tab[2] = {5{8'd255}};
    c_tab[2] = {5{8'd255}};
    e_sum[2] = 16'd62981; e_ov[2] = 1'b1;
    run_table("boundary", s_tab, c_tab, e_sum, e_ov);
  endtask

  task automatic test_reset_mid();
    logic [16:0] exp_q;
    @(negedge clk);
    drive({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    sb_q.push_back({1'b0, 16'd55});
    @(posedge clk); #1;
    exp_q = sb_q.pop_front();
    total++;
    if (bus.sum_q !== exp_q[15:0]) $display("FAIL rstmid_pre_sum_q: got %0d expected %0d", bus.sum_q, exp_q[15:0]);
    else passed++;
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (bus.sum_q !== 16'd0) $display("FAIL rstmid_sum_q: got %0d expected 0", bus.sum_q);
    else passed++;
    total++;
    if (bus.overflow_q !== 1'b0) $display("FAIL rstmid_overflow_q: got %0b expected 0", bus.overflow_q);
    else passed++;
    total++;
    if (bus.sum !== 16'd55) $display("FAIL rstmid_comb_sum: got %0d expected 55", bus.sum);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (bus.sum_q !== 16'd0) $display("FAIL rstmid_release_sum_q: got %0d expected 0", bus.sum_q);
    else passed++;
    sb_q.push_back({1'b0, 16'd55});
    @(posedge clk); #1;
    exp_q = sb_q.pop_front();
    total++;
    if (bus.sum_q !== exp_q[15:0]) $display("FAIL rstmid_resume_sum_q: got %0d expected %0d", bus.sum_q, exp_q[15:0]);
    else passed++;
  endtask

  // New operands every cycle; the registered result is checked one cycle
  // later against the scoreboard entry pushed when those operands were driven.
  task automatic test_back_to_back();
    logic [39:0] s, c;
    logic [18:0] full;
    logic [16:0] exp_q;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        exp_q = sb_q.pop_front();
        total++;
        if (bus.sum_q !== exp_q[15:0])
          $display("FAIL stream_sum_q[%0d]: got %0d expected %0d", i, bus.sum_q, exp_q[15:0]);
        else passed++;
        total++;
        if (bus.overflow_q !== exp_q[16])
          $display("FAIL stream_overflow_q[%0d]: got %0b expected %0b", i, bus.overflow_q, exp_q[16]);
        else passed++;
      end
      if (i < 20) begin
        s = {$urandom, $urandom_range(255, 0)};
        c = {$urandom, $urandom_range(255, 0)};
        if (i % 4 == 0) c = {5{8'(200 + $urandom_range(55, 0))}};
        drive(s, c);
        #1;
        full = model(s, c);
        total++;
        if (bus.sum !== full[15:0])
          $display("FAIL stream_sum[%0d]: got %0d expected %0d", i, bus.sum, full[15:0]);
        else passed++;
        total++;
        if (bus.overflow !== (|full[18:16]))
          $display("FAIL stream_overflow[%0d]: got %0b expected %0b", i, bus.overflow, |full[18:16]);
        else passed++;
        sb_q.push_back({|full[18:16], full[15:0]});
      end
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_overflow_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
